// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM state type and datapath defaults for the
// execute stage and the upstream ALU control decoder.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial shifter: moves the operand one bit position per cycle and flags the
// final step so the caller can capture the shifted value combinationally.
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic               left,
  input  logic               arith,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] amount,
  output logic               done,
  output logic [XLEN-1:0]    data_next
);

  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               left_q;
  logic               arith_q;

  // data_next is the value after the step taken this cycle; on the last step
  // it is the final result.
  assign data_next = left_q ? {data_q[XLEN-2:0], 1'b0}
                            : {arith_q & data_q[XLEN-1], data_q[XLEN-1:1]};
  assign done      = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (start) begin
      data_q  <= data_in;
      cnt_q   <= amount;
      left_q  <= left;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      data_q <= data_next;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/logic/compare, serial shifts, and a
// registered valid/ready result stage.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    sh_next;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic               out_valid_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [TAG_W-1:0]   sh_tag_q;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               start_shift;
  logic               load_direct;
  logic               shift_finish;
  logic               sh_done;

  assign shamt = op_b[SHAMT_W-1:0];

  // Shift codes pass op_a through so a shift by zero completes in one cycle.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_shift) state_d = SHIFT;
        SHIFT:   if (sh_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_q == IDLE) && !flush && (!out_valid_q || out_ready);
    busy         = (state_q == SHIFT);
    accept       = in_valid && in_ready;
    start_shift  = accept && is_shift_op(alu_ctrl) && (shamt != '0);
    load_direct  = accept && !start_shift;
    shift_finish = (state_q == SHIFT) && sh_done && !flush;
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start_shift),
    .left      (alu_ctrl == OP_SLL),
    .arith     (alu_ctrl == OP_SRA),
    .data_in   (op_a),
    .amount    (shamt),
    .done      (sh_done),
    .data_next (sh_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tag_q <= '0;
    end else if (start_shift) begin
      sh_tag_q <= in_tag;
    end
  end

  // A new result may load in the same cycle the old one is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_tag_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_direct) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      zero_q      <= (alu_res == '0);
      out_tag_q   <= in_tag;
    end else if (shift_finish) begin
      out_valid_q <= 1'b1;
      result_q    <= sh_next;
      zero_q      <= (sh_next == '0);
      out_tag_q   <= sh_tag_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign out_tag   = out_tag_q;

endmodule
